prm_edge_mask_scan: RTL

//  Drives one 15-bit obstacle code (bits A..O) into the bank of prm_oblgc_chk* edge checkers.

---
 rtl/prm_edge_pkg.sv | 26 ++
 rtl/prm_edge_mask_scan_prio_enc.sv | 64 ++++++
 rtl/prm_edge_mask_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prm_edge_pkg.sv
// Shared types, widths and helpers for the PRM edge-mask scanner.
package prm_edge_pkg;

    localparam int unsigned OBS_W = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SCAN   = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/prm_edge_mask_scan_prio_enc.sv
// Lowest-set-bit finder built recursively from 16-bit leaves.
module prm_edge_prio_enc
    import prm_edge_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = clog2_f(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int unsigned LEAF_W = 16;

    generate
        if (N <= LEAF_W) begin : g_leaf
            // Scan high to low so the lowest set bit is the last to win.
            always_comb begin
                any_o = |vec_i;
                idx_o = '0;
                for (int i = int'(N) - 1; i >= 0; i--) begin
                    if (vec_i[i]) begin
                        idx_o = IDX_W'(i);
                    end
                end
            end
        end else begin : g_tree
            localparam int unsigned L     = (N + LEAF_W - 1) / LEAF_W;
            localparam int unsigned LW    = clog2_f(L);
            localparam int unsigned PAD_W = L * LEAF_W;

            logic [PAD_W-1:0] vec_pad;
            logic [L-1:0]     leaf_any;
            logic [3:0]       leaf_idx [L];
            logic [LW-1:0]    leaf_sel;

            assign vec_pad = PAD_W'(vec_i);

            for (genvar l = 0; l < L; l++) begin : g_l
                prm_edge_prio_enc #(
                    .N     (LEAF_W),
                    .IDX_W (4)
                ) u_leaf (
                    .vec_i (vec_pad[l*LEAF_W +: LEAF_W]),
                    .any_o (leaf_any[l]),
                    .idx_o (leaf_idx[l])
                );
            end

            // The leaf-level any flags feed another encoder to pick the leaf.
            prm_edge_prio_enc #(
                .N     (L),
                .IDX_W (LW)
            ) u_top (
                .vec_i (leaf_any),
                .any_o (any_o),
                .idx_o (leaf_sel)
            );

            assign idx_o = IDX_W'({leaf_sel, leaf_idx[leaf_sel]});
        end
    endgenerate

endmodule

// File: rtl/prm_edge_mask_scan.sv
// Drives an obstacle code to the edge-checker bank, snapshots the settled mask and
// streams blocked-edge indices lowest first. Optional popcount output under EDGE_CNT_EN.
module prm_edge_mask_scan
    import prm_edge_pkg::*;
#(
    parameter  int unsigned N_EDGES    = 1024,
    parameter  int unsigned SETTLE_CYC = 2,
    localparam int unsigned IDX_W      = clog2_f(N_EDGES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               obs_valid_i,
    input  logic [OBS_W-1:0]   obs_code_i,
    output logic               obs_ready_o,
    output logic [OBS_W-1:0]   obs_code_o,
    input  logic [N_EDGES-1:0] edge_mask_i,
    output logic               idx_valid_o,
    output logic [IDX_W-1:0]   idx_o,
    input  logic               idx_ready_i,
    output logic               done_o,
    output logic               busy_o
`ifdef EDGE_CNT_EN
    ,
    output logic [IDX_W:0]     blocked_cnt_o
`endif
);

    localparam int unsigned CNT_W = clog2_f(SETTLE_CYC);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OBS_W-1:0]   code_q;
    logic [N_EDGES-1:0] snap_q;
    logic [N_EDGES-1:0] snap_d;
    logic               valid_q;
    logic               ready_q;
    logic               done_q;
    logic               busy_q;
    logic               enc_any;
    logic [IDX_W-1:0]   enc_idx;
    logic               hs;

    prm_edge_prio_enc #(
        .N     (N_EDGES),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_i (snap_q),
        .any_o (enc_any),
        .idx_o (enc_idx)
    );

    assign hs = valid_q & idx_ready_i & enc_any;

    // A consumed index is retired from the snapshot.
    always_comb begin
        snap_d = snap_q;
        if (hs) begin
            snap_d[enc_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (obs_valid_i) begin
                        code_q  <= obs_code_i;
                        cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                        state_q <= SETTLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        snap_q  <= edge_mask_i;
                        valid_q <= |edge_mask_i;
                        state_q <= SCAN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SCAN: begin
                    snap_q <= snap_d;
                    if (snap_d == '0) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign obs_ready_o = ready_q;
    assign obs_code_o  = code_q;
    assign idx_valid_o = valid_q;
    assign idx_o       = enc_idx;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

`ifdef EDGE_CNT_EN
    logic [IDX_W:0] pop_c;
    logic [IDX_W:0] blk_q;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(N_EDGES); i++) begin
            pop_c = pop_c + (IDX_W + 1)'(edge_mask_i[i]);
        end
    end

    // Captured alongside the snapshot and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
        end else if (state_q == SETTLE && cnt_q == '0) begin
            blk_q <= pop_c;
        end
    end

    assign blocked_cnt_o = blk_q;
`endif

endmodule
